sr_excite_driver: RTL

SR_EXCITE_DRIVER -- requirements
Module: sr_excite_driver

---
 rtl/sr_excite_driver_if.sv | 25 ++
 rtl/sr_excite_driver.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sr_excite_driver_if.sv
// rtl/sr_excite_driver_if.sv - word handshake and SR flip-flop excitation bundle
interface sr_excite_driver_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             q_fb;
  logic             S;
  logic             R;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic [7:0]       err_count;

  modport master (
    output in_valid, in_data, q_fb,
    input  in_ready, S, R, busy, done, mismatch, err_count
  );

  modport slave (
    input  in_valid, in_data, q_fb,
    output in_ready, S, R, busy, done, mismatch, err_count
  );
endinterface

// File: rtl/sr_excite_driver.sv
// rtl/sr_excite_driver.sv - drives an external SR flip-flop through a target bit sequence
// and checks its q feedback after every bit.
module sr_excite_driver #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  sr_excite_driver_if.slave   bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {INIT, IDLE, DRIVE, CHECK, DONE} state_t;

  state_t           state, state_n;
  logic             armed, armed_n;
  logic [WIDTH-1:0] word, word_n;
  logic [IW-1:0]    idx, idx_n;
  logic             m, m_n;
  logic             s_q, r_q, ready_q, busy_q, done_q, mis_q;
  logic             s_n, r_n, ready_n, busy_n, done_n, mis_n;
  logic [7:0]       err_q, err_n;
  logic [IW-1:0]    idx_inc;

  // S sets, R clears, both low holds; the two are never high together.
  function automatic logic [1:0] excite(input logic cur, input logic tgt);
    return {~cur & tgt, cur & ~tgt};
  endfunction

  assign idx_inc = idx + IW'(1);

  always_comb begin
    state_n = state;
    armed_n = armed;
    word_n  = word;
    idx_n   = idx;
    m_n     = m;
    mis_n   = mis_q;
    err_n   = err_q;
    s_n     = 1'b0;
    r_n     = 1'b0;
    ready_n = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;

    // Registered outputs are computed for the state being entered so they line up with it.
    case (state)
      INIT: begin
        if (!armed) begin
          armed_n = 1'b1;
          r_n     = 1'b1;
          m_n     = 1'b0;
        end else begin
          state_n = IDLE;
          ready_n = 1'b1;
        end
      end
      IDLE: begin
        if (bus.in_valid && ready_q) begin
          word_n     = bus.in_data;
          idx_n      = '0;
          mis_n      = 1'b0;
          state_n    = DRIVE;
          busy_n     = 1'b1;
          {s_n, r_n} = excite(m, bus.in_data[0]);
          m_n        = bus.in_data[0];
        end else begin
          ready_n = 1'b1;
        end
      end
      DRIVE: begin
        state_n = CHECK;
        busy_n  = 1'b1;
      end
      CHECK: begin
        busy_n = 1'b1;
        if (bus.q_fb != m) begin
          mis_n = 1'b1;
          if (err_q != 8'hFF) err_n = err_q + 8'd1;
        end
        if (idx != IW'(WIDTH - 1)) begin
          idx_n      = idx_inc;
          state_n    = DRIVE;
          {s_n, r_n} = excite(m, word[idx_inc]);
          m_n        = word[idx_inc];
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
      default: begin
        state_n = INIT;
        armed_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      armed   <= 1'b0;
      word    <= '0;
      idx     <= '0;
      m       <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 8'd0;
    end else begin
      state   <= state_n;
      armed   <= armed_n;
      word    <= word_n;
      idx     <= idx_n;
      m       <= m_n;
      s_q     <= s_n;
      r_q     <= r_n;
      ready_q <= ready_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      mis_q   <= mis_n;
      err_q   <= err_n;
    end
  end

  assign bus.S         = s_q;
  assign bus.R         = r_q;
  assign bus.in_ready  = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mismatch  = mis_q;
  assign bus.err_count = err_q;

endmodule
